// File: rtl/i2c_pkg.sv
// Shared I2C types and bus constants for the target (and the master's state naming space).
package i2c_pkg;

    // Target FSM states; TGT_ prefix keeps them apart from the master's states.
    typedef enum logic [3:0] {
        TGT_IDLE,
        TGT_ADDR,
        TGT_ADDR_ACK,
        TGT_REG,
        TGT_REG_ACK,
        TGT_WDATA,
        TGT_WDATA_ACK,
        TGT_RDATA,
        TGT_RDATA_ACK,
        TGT_IGNORE
    } target_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_cond.sv
// Bus line conditioner: synchroniser, optional glitch filter, edge strobes.
// Optional filter enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef I2C_TGT_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // A single flop is never an adequate synchroniser, so clamp the depth.
    localparam int SYNC_LEN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SYNC_LEN-1:0] sync_q;
    logic                sync_out;
    logic                filt;
    logic                level_d;

    // Metastability synchroniser; resets to the idle (high) bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_LEN-2:0], line};
    end

    assign sync_out = sync_q[SYNC_LEN-1];

    if (FILTER_EN && FILTER_LEN > 1) begin : g_filter
        localparam int CNT_W = $clog2(FILTER_LEN);
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
        logic [CNT_W-1:0] cnt;
        logic             filt_q;

        // Hold filter: accept a new level only after FILTER_LEN consecutive samples of it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                filt_q <= 1'b1;
            end else if (sync_out != filt_q) begin
                if (cnt == CNT_MAX) begin
                    filt_q <= sync_out;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign filt = filt_q;
    end else begin : g_bypass
        assign filt = sync_out;
    end

    // Delayed copy for single-cycle edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_d <= 1'b1;
        else     level_d <= filt;
    end

    assign level = filt;
    assign rise  = filt & ~level_d;
    assign fall  = ~filt & level_d;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address match, register pointer, multi-byte write/read.
// Optional SCL/SDA glitch filter enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h1A,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_reg,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       nack_seen
);

    target_state_t state_q, state_d;

    logic       scl_s, scl_rise, scl_fall;
    logic       sda_s, sda_rise, sda_fall;
    logic       start_det, stop_det, byte_full, addr_hit;

    logic [3:0] bit_cnt, bit_cnt_d;
    logic [7:0] shreg, shreg_d;
    logic [7:0] ptr, ptr_d;
    logic [7:0] tx, tx_d;
    logic       rw, rw_d;

    logic       sda_oe_d, busy_d, nack_d, wr_valid_d, rd_req_d;
    logic [7:0] wr_reg_d, wr_data_d, rd_reg_d;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
        .clk(clk), .rst(rst), .line(scl_i),
        .level(scl_s), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
        .clk(clk), .rst(rst), .line(sda_i),
        .level(sda_s), .rise(sda_rise), .fall(sda_fall)
    );

    // SDA may only move while SCL is high for bus conditions, never for data.
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign byte_full = (bit_cnt == 4'd8);
    assign addr_hit  = (shreg[7:1] == TARGET_ADDR);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= TGT_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: STOP beats START beats per-state protocol progress.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = TGT_IDLE;
        end else if (start_det) begin
            state_d = TGT_ADDR;
        end else begin
            case (state_q)
                TGT_ADDR:      if (scl_fall && byte_full) state_d = addr_hit ? TGT_ADDR_ACK : TGT_IGNORE;
                TGT_ADDR_ACK:  if (scl_fall) state_d = (rw == I2C_RW_READ) ? TGT_RDATA : TGT_REG;
                TGT_REG:       if (scl_fall && byte_full) state_d = TGT_REG_ACK;
                TGT_REG_ACK:   if (scl_fall) state_d = TGT_WDATA;
                TGT_WDATA:     if (scl_fall && byte_full) state_d = TGT_WDATA_ACK;
                TGT_WDATA_ACK: if (scl_fall) state_d = TGT_WDATA;
                TGT_RDATA:     if (scl_fall && byte_full) state_d = TGT_RDATA_ACK;
                TGT_RDATA_ACK: if (scl_rise) state_d = (sda_s == I2C_ACK) ? TGT_RDATA : TGT_IGNORE;
                default:       state_d = state_q;
            endcase
        end
    end

    // Output/datapath next values; sda_oe only ever changes on scl_fall or a bus condition.
    always_comb begin
        sda_oe_d   = sda_oe;
        busy_d     = busy;
        nack_d     = nack_seen;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        wr_reg_d   = wr_reg;
        wr_data_d  = wr_data;
        rd_reg_d   = rd_reg;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        ptr_d      = ptr;
        tx_d       = tx;
        rw_d       = rw;

        // Read data arrives exactly one clock after the request.
        if (rd_req) tx_d = rd_data;

        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            nack_d    = 1'b0;
        end else begin
            case (state_q)
                TGT_ADDR, TGT_REG, TGT_WDATA: begin
                    if (scl_rise && !byte_full) begin
                        shreg_d   = {shreg[6:0], sda_s};
                        bit_cnt_d = bit_cnt + 4'd1;
                        // Commit the data byte as soon as its last bit is sampled.
                        if (state_q == TGT_WDATA && bit_cnt == 4'd7) begin
                            wr_valid_d = 1'b1;
                            wr_reg_d   = ptr;
                            wr_data_d  = shreg_d;
                            ptr_d      = ptr + 8'd1;
                        end
                    end
                    if (scl_fall && byte_full) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == TGT_ADDR) begin
                            rw_d = shreg[0];
                            if (addr_hit) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                            end
                        end else begin
                            sda_oe_d = 1'b1;
                            if (state_q == TGT_REG) ptr_d = shreg;
                        end
                    end
                end
                TGT_ADDR_ACK: begin
                    // Fetch early so the byte is ready well before the first drive edge.
                    if (scl_rise && rw == I2C_RW_READ) begin
                        rd_req_d = 1'b1;
                        rd_reg_d = ptr;
                    end
                    if (scl_fall) begin
                        if (rw == I2C_RW_READ) begin
                            sda_oe_d  = ~tx[7];
                            tx_d      = {tx[6:0], 1'b0};
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                TGT_REG_ACK, TGT_WDATA_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b0;
                end
                TGT_RDATA: begin
                    if (scl_fall) begin
                        if (byte_full) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            sda_oe_d  = ~tx[7];
                            tx_d      = {tx[6:0], 1'b0};
                            bit_cnt_d = bit_cnt + 4'd1;
                        end
                    end
                end
                TGT_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            ptr_d    = ptr + 8'd1;
                            rd_req_d = 1'b1;
                            rd_reg_d = ptr + 8'd1;
                        end else begin
                            nack_d = 1'b1;
                        end
                    end
                end
                TGT_IGNORE: sda_oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Output and datapath registers; reset releases the bus immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            nack_seen <= 1'b0;
            wr_valid  <= 1'b0;
            rd_req    <= 1'b0;
            wr_reg    <= 8'h00;
            wr_data   <= 8'h00;
            rd_reg    <= 8'h00;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            ptr       <= 8'h00;
            tx        <= 8'h00;
            rw        <= I2C_RW_WRITE;
        end else begin
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
            nack_seen <= nack_d;
            wr_valid  <= wr_valid_d;
            rd_req    <= rd_req_d;
            wr_reg    <= wr_reg_d;
            wr_data   <= wr_data_d;
            rd_reg    <= rd_reg_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            ptr       <= ptr_d;
            tx        <= tx_d;
            rw        <= rw_d;
        end
    end

endmodule
